// File: rtl/text_digit_sequencer_if.sv
// Bundles the counter inputs and BCD digit outputs of the text digit sequencer.
// Latency: none (wires only).
// Backpressure: none; frame_start is a fire-and-forget pulse, ignored while busy.
//
// Signals:
//   frame_start  - one-cycle pulse at start of vertical blank
//   score        - signed game score
//   level        - signed current level
//   rows_cleared - signed total rows cleared
//   score_bcd    - 6 packed BCD digits, [23:20] most significant
//   level_bcd    - 2 packed BCD digits
//   rows_bcd     - 4 packed BCD digits
//   busy         - conversion sequence in progress
//   done         - one-cycle pulse once all three fields are committed
interface text_digit_sequencer_if;
  logic               frame_start;
  logic signed [31:0] score;
  logic signed [31:0] level;
  logic signed [31:0] rows_cleared;
  logic        [23:0] score_bcd;
  logic        [7:0]  level_bcd;
  logic        [15:0] rows_bcd;
  logic               busy;
  logic               done;

  // Game-logic / overlay side: drives counters, consumes digits.
  modport master (
    output frame_start,
    output score,
    output level,
    output rows_cleared,
    input  score_bcd,
    input  level_bcd,
    input  rows_bcd,
    input  busy,
    input  done
  );

  // Sequencer side.
  modport slave (
    input  frame_start,
    input  score,
    input  level,
    input  rows_cleared,
    output score_bcd,
    output level_bcd,
    output rows_bcd,
    output busy,
    output done
  );
endinterface

// File: rtl/text_digit_sequencer.sv
// Converts score/level/rows_cleared to packed BCD once per frame with one shared serial double-dabble.
// Latency: fixed 64 busy cycles from the accepted frame_start edge to done (3 x (20 shift + 1 write) + 1).
// Backpressure: none; frame_start is dropped while busy (including the done cycle), never queued.
//
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous, active-high; aborts any sequence and clears all outputs
//   bus   - text_digit_sequencer_if.slave (frame_start, counters in; BCD digits, busy, done out)
module text_digit_sequencer #(
  parameter int SHIFT_BITS = 20,
  parameter int SCORE_MAX  = 999999,
  parameter int LEVEL_MAX  = 99,
  parameter int ROWS_MAX   = 9999
) (
  input  logic                    Clk,
  input  logic                    Reset,
  text_digit_sequencer_if.slave   bus
);

  localparam int CNT_W = $clog2(SHIFT_BITS);
  localparam int ACC_W = 24;
  localparam int N_DIG = ACC_W / 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Negative counters read as 0, anything above the display range pins to the ceiling.
  function automatic logic [SHIFT_BITS-1:0] clamp(input logic signed [31:0] v, input int max);
    logic [SHIFT_BITS-1:0] r;
    if (v < 0) begin
      r = '0;
    end else if (v > max) begin
      r = SHIFT_BITS'(max);
    end else begin
      r = SHIFT_BITS'(v);
    end
    return r;
  endfunction

  // Double-dabble correction: any digit >= 5 would overflow past 9 after the
  // upcoming doubling, so add 3 first to push the carry into the next digit.
  function automatic logic [ACC_W-1:0] dd_adjust(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < N_DIG; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             field_q, field_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  // bin_q doubles as the score snapshot: it is loaded with the clamped score
  // at frame_start and consumed first, so no separate score copy is kept.
  logic [SHIFT_BITS-1:0]  bin_q, bin_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [SHIFT_BITS-1:0]  snap_level_q, snap_level_d;
  logic [SHIFT_BITS-1:0]  snap_rows_q, snap_rows_d;
  logic [23:0]            score_bcd_q, score_bcd_d;
  logic [7:0]             level_bcd_q, level_bcd_d;
  logic [15:0]            rows_bcd_q, rows_bcd_d;
  logic [ACC_W-1:0]       acc_adj;

  assign acc_adj = dd_adjust(acc_q);

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      field_q      <= '0;
      cnt_q        <= '0;
      bin_q        <= '0;
      acc_q        <= '0;
      snap_level_q <= '0;
      snap_rows_q  <= '0;
      score_bcd_q  <= '0;
      level_bcd_q  <= '0;
      rows_bcd_q   <= '0;
    end else begin
      state_q      <= state_d;
      field_q      <= field_d;
      cnt_q        <= cnt_d;
      bin_q        <= bin_d;
      acc_q        <= acc_d;
      snap_level_q <= snap_level_d;
      snap_rows_q  <= snap_rows_d;
      score_bcd_q  <= score_bcd_d;
      level_bcd_q  <= level_bcd_d;
      rows_bcd_q   <= rows_bcd_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d      = state_q;
    field_d      = field_q;
    cnt_d        = cnt_q;
    bin_d        = bin_q;
    acc_d        = acc_q;
    snap_level_d = snap_level_q;
    snap_rows_d  = snap_rows_q;
    score_bcd_d  = score_bcd_q;
    level_bcd_d  = level_bcd_q;
    rows_bcd_d   = rows_bcd_q;

    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          bin_d        = clamp(bus.score, SCORE_MAX);
          snap_level_d = clamp(bus.level, LEVEL_MAX);
          snap_rows_d  = clamp(bus.rows_cleared, ROWS_MAX);
          field_d      = 2'd0;
          cnt_d        = '0;
          acc_d        = '0;
          state_d      = CONV;
        end
      end

      CONV: begin
        {acc_d, bin_d} = {acc_adj, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SHIFT_BITS - 1)) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        // Only the field just converted is touched; the others keep last frame's digits.
        case (field_q)
          2'd0:    score_bcd_d = acc_q;
          2'd1:    level_bcd_d = acc_q[7:0];
          default: rows_bcd_d  = acc_q[15:0];
        endcase
        if (field_q < 2'd2) begin
          field_d = field_q + 2'd1;
          bin_d   = (field_q == 2'd0) ? snap_level_q : snap_rows_q;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        // frame_start here is deliberately not looked at.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.score_bcd = score_bcd_q;
  assign bus.level_bcd = level_bcd_q;
  assign bus.rows_bcd  = rows_bcd_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule
